// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard/request inputs from the pipeline stages and the
// per-register Write/clear, PC enable and status outputs back to the datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             load_use;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             halt_req;
  logic             resume;

  logic             pc_write;
  logic             wr_if_id;
  logic             wr_id_ex;
  logic             wr_ex_mem;
  logic             wr_mem_wr;
  logic             clr_if_id;
  logic             clr_id_ex;
  logic             clr_ex_mem;
  logic             clr_mem_wr;
  logic [2:0]       state;
  logic             mem_error;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output load_use, branch_taken, mem_req, mem_ready, halt_req, resume,
    input  pc_write, wr_if_id, wr_id_ex, wr_ex_mem, wr_mem_wr,
    input  clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wr,
    input  state, mem_error, stall_count
  );

  modport slave (
    input  load_use, branch_taken, mem_req, mem_ready, halt_req, resume,
    output pc_write, wr_if_id, wr_id_ex, wr_ex_mem, wr_mem_wr,
    output clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wr,
    output state, mem_error, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory waits with timeout, halt/drain, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int DRAIN_CYC   = 3,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   clear_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    MEM_WAIT   = 3'd2,
    DRAIN      = 3'd3,
    HALT       = 3'd4,
    ERROR      = 3'd5
  } state_e;

  // wr/clr bit order: {if_id, id_ex, ex_mem, mem_wr}
  typedef struct packed {
    logic       pc_write;
    logic [3:0] wr;
    logic [3:0] clr;
  } ctrl_t;

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, wr: 4'b1111, clr: 4'b0000};
  localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, wr: 4'b1111, clr: 4'b1100};
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, wr: 4'b0111, clr: 4'b0100};
  localparam ctrl_t CTRL_DRAIN  = '{pc_write: 1'b0, wr: 4'b1111, clr: 4'b1000};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, wr: 4'b0000, clr: 4'b0000};
  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, wr: 4'b0000, clr: 4'b1111};

  state_e             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0]   r_stall_count;
  logic               r_mem_error;

  state_e             w_next_state;
  logic [WAIT_W-1:0]  w_next_wait;
  logic [DRAIN_W-1:0] w_next_drain;
  ctrl_t              w_ctrl;
  ctrl_t              w_out;
  logic               w_mem_stall;
  logic               w_count_stall;

  assign w_mem_stall = bus.mem_req && !bus.mem_ready;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    w_next_drain = r_drain_cnt;
    w_ctrl       = CTRL_RUN;

    case (r_state)
      RUN, LOAD_STALL: begin
        // LOAD_STALL is a single bubble: load_use and halt_req are not re-honoured there.
        w_next_state = RUN;
        if (w_mem_stall) begin
          w_ctrl       = CTRL_FREEZE;
          w_next_state = MEM_WAIT;
          w_next_wait  = WAIT_W'(1);
        end else if (bus.branch_taken) begin
          w_ctrl = CTRL_FLUSH;
        end else if (r_state == RUN && bus.load_use) begin
          w_ctrl       = CTRL_BUBBLE;
          w_next_state = LOAD_STALL;
        end else if (r_state == RUN && bus.halt_req) begin
          w_ctrl       = CTRL_DRAIN;
          w_next_state = DRAIN;
          w_next_drain = DRAIN_W'(1);
        end
      end

      MEM_WAIT: begin
        if (!bus.mem_ready) begin
          w_ctrl = CTRL_FREEZE;
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            w_next_state = ERROR;
          end else begin
            w_next_wait = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          w_next_state = RUN;
          if (bus.branch_taken) begin
            w_ctrl = CTRL_FLUSH;
          end else if (bus.load_use) begin
            w_ctrl       = CTRL_BUBBLE;
            w_next_state = LOAD_STALL;
          end
        end
      end

      DRAIN: begin
        if (w_mem_stall) begin
          w_ctrl = CTRL_FREEZE;
        end else begin
          w_ctrl = CTRL_DRAIN;
          if (r_drain_cnt == DRAIN_W'(DRAIN_CYC)) begin
            w_next_state = HALT;
          end else begin
            w_next_drain = r_drain_cnt + DRAIN_W'(1);
          end
        end
      end

      HALT: begin
        if (bus.resume) begin
          w_next_state = RUN;
        end else begin
          w_ctrl = CTRL_FREEZE;
        end
      end

      ERROR: w_ctrl = CTRL_FREEZE;

      default: w_next_state = RUN;
    endcase
  end

  assign w_out = clear_n ? w_ctrl : CTRL_RESET;

  assign w_count_stall = !w_ctrl.pc_write &&
                         (r_state inside {RUN, LOAD_STALL, MEM_WAIT, DRAIN});

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_stall_count <= '0;
      r_mem_error   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_wait_cnt  <= w_next_wait;
      r_drain_cnt <= w_next_drain;
      if (w_count_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_next_state == ERROR) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  assign bus.pc_write    = w_out.pc_write;
  assign bus.wr_if_id    = w_out.wr[3];
  assign bus.wr_id_ex    = w_out.wr[2];
  assign bus.wr_ex_mem   = w_out.wr[1];
  assign bus.wr_mem_wr   = w_out.wr[0];
  assign bus.clr_if_id   = w_out.clr[3];
  assign bus.clr_id_ex   = w_out.clr[2];
  assign bus.clr_ex_mem  = w_out.clr[1];
  assign bus.clr_mem_wr  = w_out.clr[0];
  assign bus.state       = r_state;
  assign bus.mem_error   = r_mem_error;
  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, hand-written corner sequences,
// and random stimulus against a hazard-priority reference model; a 3-bit-counter twin checks saturation.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int DRAIN_CYC   = 3;
  localparam int SMALL_MAX   = 7;

  // stim bits: [6]=clear_n [5]=load_use [4]=branch_taken [3]=mem_req [2]=mem_ready [1]=halt_req [0]=resume
  typedef logic [6:0] stim_t;
  localparam stim_t S_RST   = 7'b0_000000;
  localparam stim_t S_IDLE  = 7'b1_000000;
  localparam stim_t S_LD    = 7'b1_100000;
  localparam stim_t S_LDBR  = 7'b1_110000;
  localparam stim_t S_MWAIT = 7'b1_001000;
  localparam stim_t S_MDONE = 7'b1_001100;
  localparam stim_t S_HALT  = 7'b1_000010;
  localparam stim_t S_RES   = 7'b1_000001;

  // ctrl bits: {pc_write, wr_if_id, wr_id_ex, wr_ex_mem, wr_mem_wr, clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wr}
  localparam logic [8:0] C_DEF    = 9'b1_1111_0000;
  localparam logic [8:0] C_FLUSH  = 9'b1_1111_1100;
  localparam logic [8:0] C_BUBBLE = 9'b0_0111_0100;
  localparam logic [8:0] C_DRAIN  = 9'b0_1111_1000;
  localparam logic [8:0] C_FREEZE = 9'b0_0000_0000;
  localparam logic [8:0] C_RESET  = 9'b0_0000_1111;

  localparam int M_RUN = 0, M_LS = 1, M_MW = 2, M_DR = 3, M_HALT = 4, M_ERR = 5;

  typedef struct {
    stim_t      in;
    logic [8:0] ctrl;
    logic [2:0] st;
    int         cnt;
    bit         chk_reg;
  } vec_t;

  logic clock;
  logic clear_n;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  bus_s ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYC(DRAIN_CYC), .CNT_W(16)) u_dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYC(DRAIN_CYC), .CNT_W(3)) u_dut_small (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus_s)
  );

  assign bus_s.load_use     = bus.load_use;
  assign bus_s.branch_taken = bus.branch_taken;
  assign bus_s.mem_req      = bus.mem_req;
  assign bus_s.mem_ready    = bus.mem_ready;
  assign bus_s.halt_req     = bus.halt_req;
  assign bus_s.resume       = bus.resume;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_ctrl();
    return {bus.pc_write, bus.wr_if_id, bus.wr_id_ex, bus.wr_ex_mem, bus.wr_mem_wr,
            bus.clr_if_id, bus.clr_id_ex, bus.clr_ex_mem, bus.clr_mem_wr};
  endfunction

  task automatic drive(input stim_t s);
    clear_n          = s[6];
    bus.load_use     = s[5];
    bus.branch_taken = s[4];
    bus.mem_req      = s[3];
    bus.mem_ready    = s[2];
    bus.halt_req     = s[1];
    bus.resume       = s[0];
  endtask

  // Reference model: each mode honours a subset of hazards; the highest-priority honoured one wins.
  int m_mode, m_frozen, m_drain_left, m_stalls;
  bit m_err, m_known;

  // hazard codes: 0 none, 1 memory stall, 2 branch, 3 load-use, 4 halt
  function automatic int pick(input logic [3:0] honour, input stim_t s);
    logic [3:0] active;
    logic [3:0] hit;
    active = {s[3] & ~s[2], s[4], s[5], s[1]};
    hit    = honour & active;
    if (hit[3]) return 1;
    if (hit[2]) return 2;
    if (hit[1]) return 3;
    if (hit[0]) return 4;
    return 0;
  endfunction

  task automatic model_check_and_clock(input stim_t s);
    logic [8:0] exp;
    int n_mode, n_frozen, n_drain_left, n_stalls, hz;
    bit n_err;
    n_mode = m_mode; n_frozen = m_frozen; n_drain_left = m_drain_left;
    n_stalls = m_stalls; n_err = m_err;
    if (!s[6]) begin
      exp = C_RESET;
      n_mode = M_RUN; n_frozen = 0; n_drain_left = 0; n_stalls = 0; n_err = 0;
    end else begin
      exp = C_DEF;
      case (m_mode)
        M_RUN, M_LS: begin
          hz = pick((m_mode == M_RUN) ? 4'b1111 : 4'b1100, s);
          n_mode = M_RUN;
          case (hz)
            1: begin exp = C_FREEZE; n_mode = M_MW; n_frozen = 1; end
            2: exp = C_FLUSH;
            3: begin exp = C_BUBBLE; n_mode = M_LS; end
            4: begin exp = C_DRAIN; n_mode = M_DR; n_drain_left = DRAIN_CYC; end
            default: ;
          endcase
        end
        M_MW: begin
          if (!s[2]) begin
            exp = C_FREEZE;
            n_frozen = m_frozen + 1;
            if (n_frozen == MEM_TIMEOUT) n_mode = M_ERR;
          end else begin
            hz = pick(4'b0110, s);
            n_mode = M_RUN;
            if (hz == 2) exp = C_FLUSH;
            else if (hz == 3) begin exp = C_BUBBLE; n_mode = M_LS; end
          end
        end
        M_DR: begin
          if (pick(4'b1000, s) == 1) begin
            exp = C_FREEZE;
          end else begin
            exp = C_DRAIN;
            n_drain_left = m_drain_left - 1;
            if (n_drain_left == 0) n_mode = M_HALT;
          end
        end
        M_HALT: begin
          if (s[0]) n_mode = M_RUN;
          else exp = C_FREEZE;
        end
        default: exp = C_FREEZE;
      endcase
      if (m_mode <= M_DR && !exp[8]) n_stalls = m_stalls + 1;
      if (n_mode == M_ERR) n_err = 1;
    end

    if (m_known || !s[6]) check("model_ctrl", 32'(dut_ctrl()), 32'(exp));
    if (m_known) begin
      check("model_state", 32'(bus.state), 32'(m_mode));
      check("model_mem_error", 32'(bus.mem_error), 32'(m_err));
      check("model_stall_count", 32'(bus.stall_count), 32'(m_stalls));
      check("model_stall_count_sat", 32'(bus_s.stall_count),
            32'((m_stalls > SMALL_MAX) ? SMALL_MAX : m_stalls));
    end

    @(posedge clock);
    #1;
    m_mode = n_mode; m_frozen = n_frozen; m_drain_left = n_drain_left;
    m_stalls = n_stalls; m_err = n_err;
    if (!s[6]) m_known = 1;
  endtask

  task automatic step(input stim_t s);
    drive(s);
    #1;
    model_check_and_clock(s);
  endtask

  function automatic vec_t v(input stim_t in, input logic [8:0] ctrl, input logic [2:0] st,
                             input int cnt, input bit chk);
    vec_t r;
    r.in = in; r.ctrl = ctrl; r.st = st; r.cnt = cnt; r.chk_reg = chk;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    stim_t s;
    int rdy_pct;

    m_known = 0; m_mode = 0; m_frozen = 0; m_drain_left = 0; m_stalls = 0; m_err = 0;
    drive(S_RST);

    // reset, load-use, load-use+branch, reset, memory wait, halt/drain/resume
    tbl.push_back(v(S_RST,   C_RESET,  3'd0, 0, 0));
    tbl.push_back(v(S_RST,   C_RESET,  3'd0, 0, 1));
    tbl.push_back(v(S_IDLE,  C_DEF,    3'd0, 0, 1));
    tbl.push_back(v(S_LD,    C_BUBBLE, 3'd0, 0, 1));
    tbl.push_back(v(S_LD,    C_DEF,    3'd1, 1, 1));
    tbl.push_back(v(S_IDLE,  C_DEF,    3'd0, 1, 1));
    tbl.push_back(v(S_LDBR,  C_FLUSH,  3'd0, 1, 1));
    tbl.push_back(v(S_IDLE,  C_DEF,    3'd0, 1, 1));
    tbl.push_back(v(S_RST,   C_RESET,  3'd0, 1, 1));
    tbl.push_back(v(S_IDLE,  C_DEF,    3'd0, 0, 1));
    tbl.push_back(v(S_MWAIT, C_FREEZE, 3'd0, 0, 1));
    tbl.push_back(v(S_MWAIT, C_FREEZE, 3'd2, 1, 1));
    tbl.push_back(v(S_MWAIT, C_FREEZE, 3'd2, 2, 1));
    tbl.push_back(v(S_MWAIT, C_FREEZE, 3'd2, 3, 1));
    tbl.push_back(v(S_MDONE, C_DEF,    3'd2, 4, 1));
    tbl.push_back(v(S_IDLE,  C_DEF,    3'd0, 4, 1));
    tbl.push_back(v(S_HALT,  C_DRAIN,  3'd0, 4, 1));
    tbl.push_back(v(S_IDLE,  C_DRAIN,  3'd3, 5, 1));
    tbl.push_back(v(S_IDLE,  C_DRAIN,  3'd3, 6, 1));
    tbl.push_back(v(S_IDLE,  C_DRAIN,  3'd3, 7, 1));
    tbl.push_back(v(S_IDLE,  C_FREEZE, 3'd4, 8, 1));
    tbl.push_back(v(S_IDLE,  C_FREEZE, 3'd4, 8, 1));
    tbl.push_back(v(S_RES,   C_DEF,    3'd4, 8, 1));
    tbl.push_back(v(S_IDLE,  C_DEF,    3'd0, 8, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      #1;
      check($sformatf("tbl%0d_ctrl", i), 32'(dut_ctrl()), 32'(tbl[i].ctrl));
      if (tbl[i].chk_reg) begin
        check($sformatf("tbl%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
        check($sformatf("tbl%0d_stall_count", i), 32'(bus.stall_count), 32'(tbl[i].cnt));
      end
      model_check_and_clock(tbl[i].in);
    end

    // memory timeout: 16 frozen cycles then sticky ERROR until reset
    step(S_RST);
    step(S_IDLE);
    repeat (MEM_TIMEOUT) step(S_MWAIT);
    check("timeout_state", 32'(bus.state), 32'd5);
    check("timeout_mem_error", 32'(bus.mem_error), 32'd1);
    check("timeout_stall_count", 32'(bus.stall_count), 32'(MEM_TIMEOUT));
    check("timeout_small_sat", 32'(bus_s.stall_count), 32'(SMALL_MAX));
    repeat (3) step(S_MDONE);
    check("error_sticky_state", 32'(bus.state), 32'd5);
    check("error_no_count", 32'(bus.stall_count), 32'(MEM_TIMEOUT));
    step(S_RST);
    check("error_clear_state", 32'(bus.state), 32'd0);
    check("error_clear_flag", 32'(bus.mem_error), 32'd0);

    // reset in the middle of a drain
    step(S_IDLE);
    step(S_HALT);
    step(S_IDLE);
    check("drain_entered", 32'(bus.state), 32'd3);
    step(S_RST);
    check("midop_reset_state", 32'(bus.state), 32'd0);
    check("midop_reset_count", 32'(bus.stall_count), 32'd0);

    // random phases with varying memory readiness
    for (int ph = 0; ph < 4; ph++) begin
      rdy_pct = (ph == 0) ? 60 : (ph == 1) ? 30 : (ph == 2) ? 4 : 85;
      for (int c = 0; c < 1000; c++) begin
        s[6] = ($urandom_range(63) != 0);
        s[5] = ($urandom_range(3) == 0);
        s[4] = ($urandom_range(6) == 0);
        s[3] = ($urandom_range(2) == 0);
        s[2] = ($urandom_range(99) < rdy_pct);
        s[1] = ($urandom_range(15) == 0);
        s[0] = ($urandom_range(3) == 0);
        step(s);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
